// File: rtl/emu_xactor_param.sv
// Parametrised co-emulation transactor: byte-serial host port, N-step DUT run, automatic capture.
// Optional 32-bit dut_ce cycle counter at readback addresses NO..NO+3 when EMU_CYCLE_CNT_EN is defined.
module emu_xactor_param #(
  parameter int IN_WIDTH  = 24,
  parameter int OUT_WIDTH = 24,
  parameter int ADDR_W    = 4
) (
  input  logic                 clk_emu,
  input  logic                 rst_emu_n,
  input  logic [7:0]           Din_emu,
  input  logic [ADDR_W-1:0]    Addr_emu,
  input  logic                 wr_emu,
  input  logic                 load_emu,
  input  logic                 get_emu,
  input  logic                 run_emu,
  output logic [7:0]           Dout_emu,
  output logic                 busy_emu,
  output logic [IN_WIDTH-1:0]  dut_in,
  input  logic [OUT_WIDTH-1:0] dut_out,
  output logic                 dut_ce
);

  localparam int unsigned NI = (IN_WIDTH + 7) / 8;
  localparam int unsigned NO = (OUT_WIDTH + 7) / 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_CAPTURE
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [7:0]            r_step;
  logic [IN_WIDTH-1:0]   r_stim;
  logic [OUT_WIDTH-1:0]  r_rb;
  logic [7:0]            w_rd_byte;
  int unsigned           w_addr;
  logic                  w_idle;
  logic                  w_cmd_any;
  logic                  w_do_load;
  logic                  w_do_get;
  logic                  w_do_run;
  logic                  w_do_wr;
  logic                  w_do_cap;

  assign w_addr = 32'(Addr_emu);
  assign w_idle = (r_state == S_IDLE);

  // Fixed priority load > get > run > wr; a run with count 0 still claims the slot.
  assign w_cmd_any = load_emu | get_emu | run_emu;
  assign w_do_load = w_idle & load_emu;
  assign w_do_get  = w_idle & ~load_emu & get_emu;
  assign w_do_run  = w_idle & ~load_emu & ~get_emu & run_emu & (Din_emu != 8'd0);
  assign w_do_wr   = wr_emu & (~w_idle | ~w_cmd_any) & (w_addr < NI);
  assign w_do_cap  = w_do_get | (r_state == S_CAPTURE);

  always_ff @(posedge clk_emu or negedge rst_emu_n) begin
    if (!rst_emu_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_do_run) w_next = S_RUN;
      S_RUN:     if (r_step == 8'd1) w_next = S_CAPTURE;
      S_CAPTURE: w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy_emu = (r_state != S_IDLE);
    dut_ce   = (r_state == S_RUN);
  end

  always_ff @(posedge clk_emu or negedge rst_emu_n) begin
    if (!rst_emu_n) begin
      r_step <= '0;
    end else if (w_do_run) begin
      r_step <= Din_emu;
    end else if (r_state == S_RUN) begin
      r_step <= r_step - 8'd1;
    end
  end

  // Banks are held at exact bit width; bits past the vector in the last byte simply do not exist.
  always_ff @(posedge clk_emu or negedge rst_emu_n) begin
    if (!rst_emu_n) begin
      r_stim <= '0;
    end else begin
      for (int unsigned b = 0; b < IN_WIDTH; b++) begin
        if (w_do_wr && (w_addr == b / 8)) r_stim[b] <= Din_emu[b % 8];
      end
    end
  end

  always_ff @(posedge clk_emu or negedge rst_emu_n) begin
    if (!rst_emu_n) begin
      dut_in <= '0;
    end else if (w_do_load) begin
      dut_in <= r_stim;
    end
  end

  always_ff @(posedge clk_emu or negedge rst_emu_n) begin
    if (!rst_emu_n) begin
      r_rb <= '0;
    end else if (w_do_cap) begin
      r_rb <= dut_out;
    end
  end

`ifdef EMU_CYCLE_CNT_EN
  logic [31:0] r_cyc;
  logic [31:0] r_snap;
  logic [31:0] w_cyc_view;

  always_ff @(posedge clk_emu or negedge rst_emu_n) begin
    if (!rst_emu_n) begin
      r_cyc <= '0;
    end else if (w_do_load && (Addr_emu == '1)) begin
      r_cyc <= '0;
    end else if (r_state == S_RUN) begin
      r_cyc <= r_cyc + 32'd1;
    end
  end

  // Reading the low byte latches the whole count so the next three bytes match it.
  always_ff @(posedge clk_emu or negedge rst_emu_n) begin
    if (!rst_emu_n) begin
      r_snap <= '0;
    end else if (w_addr == NO) begin
      r_snap <= r_cyc;
    end
  end

  assign w_cyc_view = (w_addr == NO) ? r_cyc : r_snap;
`endif

  always_comb begin
    w_rd_byte = '0;
    for (int unsigned b = 0; b < OUT_WIDTH; b++) begin
      if (w_addr == b / 8) w_rd_byte[b % 8] = r_rb[b];
    end
`ifdef EMU_CYCLE_CNT_EN
    for (int unsigned k = 0; k < 4; k++) begin
      if (w_addr == NO + k) w_rd_byte = w_cyc_view[k*8 +: 8];
    end
`endif
  end

  always_ff @(posedge clk_emu or negedge rst_emu_n) begin
    if (!rst_emu_n) begin
      Dout_emu <= '0;
    end else begin
      Dout_emu <= w_rd_byte;
    end
  end

endmodule

// File: tb/tb_emu_xactor_param.sv
// Scoreboard bench for emu_xactor_param: 24-bit instance with counter/loopback DUT, 12-bit instance with loopback.
module tb_emu_xactor_param;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr, load, get, run;
  logic [7:0]  din;
  logic [3:0]  addr;
  logic [7:0]  dout1, dout2;
  logic        busy1, busy2, ce1, ce2;
  logic [23:0] dut_in1, dut_out1;
  logic [11:0] dut_in2, dut_out2;
  logic        mode;
  logic [23:0] cnt = '0;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int         which;
    logic [7:0] exp;
  } rd_t;
  rd_t sb_q[$];

  always #5 clk = ~clk;

  assign dut_out1 = mode ? cnt : dut_in1;
  assign dut_out2 = dut_in2;

  always @(posedge clk) if (ce1) cnt <= cnt + 24'd1;

  emu_xactor_param #(.IN_WIDTH(24), .OUT_WIDTH(24), .ADDR_W(4)) u_dut1 (
    .clk_emu(clk), .rst_emu_n(rst_n), .Din_emu(din), .Addr_emu(addr),
    .wr_emu(wr), .load_emu(load), .get_emu(get), .run_emu(run),
    .Dout_emu(dout1), .busy_emu(busy1), .dut_in(dut_in1), .dut_out(dut_out1), .dut_ce(ce1)
  );

  emu_xactor_param #(.IN_WIDTH(12), .OUT_WIDTH(12), .ADDR_W(4)) u_dut2 (
    .clk_emu(clk), .rst_emu_n(rst_n), .Din_emu(din), .Addr_emu(addr),
    .wr_emu(wr), .load_emu(load), .get_emu(get), .run_emu(run),
    .Dout_emu(dout2), .busy_emu(busy2), .dut_in(dut_in2), .dut_out(dut_out2), .dut_ce(ce2)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input int which, input logic [3:0] a, input logic [7:0] e);
    rd_t t;
    addr = a;
    sb_q.push_back('{which, e});
    tick;
    t = sb_q.pop_front();
    check($sformatf("rd%0d[%0d]", t.which, a), (t.which == 2) ? dout2 : dout1, t.exp);
  endtask

  task automatic wr_byte(input logic [3:0] a, input logic [7:0] d);
    wr = 1'b1; addr = a; din = d;
    tick;
    wr = 1'b0;
  endtask

  task automatic do_load(input logic [3:0] a);
    load = 1'b1; addr = a;
    tick;
    load = 1'b0;
  endtask

  task automatic do_run(input logic [7:0] n);
    run = 1'b1; din = n;
    tick;
    run = 1'b0; din = 8'h00;
  endtask

  task automatic wait_idle;
    for (int k = 0; k < 400 && busy1; k++) tick;
    check("idle_timeout", busy1, 1'b0);
  endtask

  initial begin
    logic [23:0] start, e;
    int nb, nce, first, last;
    rst_n = 1'b0; wr = 0; load = 0; get = 0; run = 0; din = '0; addr = '0; mode = 1'b0;
    tick;
    check("rst_busy", busy1, 1'b0);
    check("rst_ce", ce1, 1'b0);
    check("rst_din", dut_in1, 24'h0);
    check("rst_ce2", ce2, 1'b0);
    check("rst_busy2", busy2, 1'b0);
    rst_n = 1'b1;
    tick;
    for (int a = 0; a < 16; a++) rd(1, 4'(a), 8'h00);

    // Write/load/loopback/get
    wr_byte(4'd0, 8'h11); wr_byte(4'd1, 8'h22); wr_byte(4'd2, 8'h33);
    do_load(4'd0);
    check("load24", dut_in1, 24'h332211);
    check("load12", dut_in2, 12'h211);
    get = 1'b1; tick; get = 1'b0;
    rd(1, 4'd0, 8'h11); rd(1, 4'd1, 8'h22); rd(1, 4'd2, 8'h33); rd(1, 4'd3, 8'h00);

    // Run 5 on the counter DUT, with a write landing mid-run
    mode = 1'b1;
    start = cnt;
    do_run(8'd5);
    nb = 0; nce = 0; first = -1; last = -1;
    for (int i = 0; i < 20; i++) begin
      if (busy1) nb++;
      if (ce1) begin
        nce++;
        if (first < 0) first = i;
        last = i;
      end
      if (i == 2) begin wr = 1'b1; addr = 4'd0; din = 8'hAA; end
      else wr = 1'b0;
      tick;
    end
    check("run5_ce", nce, 5);
    check("run5_busy", nb, 6);
    check("run5_contig", last - first, 4);
    check("run_din_held", dut_in1, 24'h332211);
    e = start + 24'd5;
    rd(1, 4'd0, e[7:0]); rd(1, 4'd1, e[15:8]); rd(1, 4'd2, e[23:16]);

    // Run with count 0 is a no-op
    do_run(8'd0);
    nb = 0; nce = 0;
    for (int i = 0; i < 3; i++) begin
      if (busy1) nb++;
      if (ce1) nce++;
      tick;
    end
    check("run0_ce", nce, 0);
    check("run0_busy", nb, 0);

    // load + get + wr together: only load
    mode = 1'b0;
    load = 1'b1; get = 1'b1; wr = 1'b1; addr = 4'd1; din = 8'h55;
    tick;
    load = 1'b0; get = 1'b0; wr = 1'b0;
    check("prio_load", dut_in1, 24'h3322AA);
    rd(1, 4'd0, e[7:0]);
    do_load(4'd0);
    check("prio_nowr", dut_in1, 24'h3322AA);

    // Partial last byte and out-of-range addresses
    wr_byte(4'd1, 8'hFF);
    wr_byte(4'd5, 8'h77);
    do_load(4'd0);
    check("w12_top", dut_in2[11:8], 4'hF);
    check("w12_all", dut_in2, 12'hFAA);
    check("w24_all", dut_in1, 24'h33FFAA);
    get = 1'b1; tick; get = 1'b0;
    rd(2, 4'd1, 8'h0F); rd(2, 4'd0, 8'hAA); rd(2, 4'd7, 8'h00);
    rd(1, 4'd2, 8'h33); rd(1, 4'd5, 8'h00);

    // Asynchronous reset in the middle of a run
    do_run(8'd50);
    tick; tick;
    check("mid_ce", ce1, 1'b1);
    check("mid_busy", busy1, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_ce", ce1, 1'b0);
    check("arst_busy", busy1, 1'b0);
    check("arst_din", dut_in1, 24'h0);
    tick;
    rst_n = 1'b1;
    tick;
    rd(1, 4'd0, 8'h00); rd(1, 4'd2, 8'h00);

    // Cycle counter: 200 + 100 = 0x12C
    do_run(8'd200); wait_idle;
    do_run(8'd100); wait_idle;
`ifdef EMU_CYCLE_CNT_EN
    rd(1, 4'd3, 8'h2C); rd(1, 4'd4, 8'h01); rd(1, 4'd5, 8'h00); rd(1, 4'd6, 8'h00);
    do_load(4'd15);
    rd(1, 4'd3, 8'h00); rd(1, 4'd4, 8'h00);
`else
    rd(1, 4'd3, 8'h00); rd(1, 4'd4, 8'h00); rd(1, 4'd5, 8'h00); rd(1, 4'd6, 8'h00);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/emu_xactor_param.md
Name: emu_xactor_param

Overview:
- Parametrised co-emulation transactor; successor of the fixed 3-byte fir8 wrapper.
- Byte-serial host port fills a stimulus bank of any width, applies it to the DUT, and steps the DUT a programmed number of clock-enable cycles. The DUT output is then captured into a readback bank automatically.
- Sits between the MCU byte bus and one DUT instance. DUT is clocked by clk_emu and gated by dut_ce; no second clock.

Parameters:
- IN_WIDTH, 24, DUT input vector width in bits (1..64); NI = ceil(IN_WIDTH/8) stimulus bytes.
- OUT_WIDTH, 24, DUT output vector width in bits (1..64); NO = ceil(OUT_WIDTH/8) capture bytes.
- ADDR_W, 4, host byte-address width; must satisfy 2^ADDR_W >= max(NI, NO+4).

Ports:
- clk_emu  in  1  single clock for transactor and DUT.
- rst_emu_n  in  1  asynchronous active-low reset.
- Din_emu  in  8  host write data.
- Addr_emu  in  ADDR_W  host byte address.
- wr_emu  in  1  write Din_emu into stimulus byte Addr_emu.
- load_emu  in  1  transfer stimulus bank to dut_in.
- get_emu  in  1  manual capture of dut_out into readback bank.
- run_emu  in  1  start stepping; step count = Din_emu.
- Dout_emu  out  8  registered readback byte.
- busy_emu  out  1  high while stepping/capturing.
- dut_in  out  IN_WIDTH  registered DUT input vector.
- dut_out  in  OUT_WIDTH  DUT output vector.
- dut_ce  out  1  DUT clock enable, one pulse per step.

Behaviour:
- Interface: one clock, clk_emu; reset rst_emu_n is asynchronous, active-low.
- Reset values: Dout_emu=0, busy_emu=0, dut_ce=0, dut_in=0; stimulus bank, readback bank and step counter = 0; FSM=IDLE.
- Byte mapping: byte k holds bits [8k+7:8k]. Unused upper bits of the last byte are ignored on write and read as 0.
- Command priority in IDLE, same cycle: load_emu > get_emu > run_emu > wr_emu. Only the highest-priority command executes.
- wr_emu: stim[Addr_emu] <= Din_emu when Addr_emu < NI. Otherwise ignored. Accepted in any state.
- load_emu: dut_in <= stimulus bank on the next edge. Ignored while busy.
- get_emu: readback bank <= dut_out on the next edge. Ignored while busy.
- Readback: Dout_emu <= rb[Addr_emu] every cycle, giving 1-cycle latency. Addresses >= NO return 0x00 (except under the optional feature).
- FSM states:
  - IDLE: run_emu with Din_emu != 0 → stepcnt <= Din_emu, go RUN, busy_emu=1 from the next cycle. run_emu with Din_emu == 0 is a no-op.
  - RUN: dut_ce=1 each cycle; stepcnt decrements; at stepcnt==1 → CAPTURE. Exactly N dut_ce pulses for count N (1..255), contiguous.
  - CAPTURE: dut_ce=0; readback bank <= dut_out (DUT state after the N-th edge); → IDLE, busy_emu=0 the next cycle.
- Total busy duration for count N: N+1 cycles.
- dut_ce is driven from the FSM register, never combinationally from inputs.
- Reset mid-RUN: immediate abort; dut_ce=0 and busy_emu=0 asynchronously; all banks cleared.
- wr_emu during RUN does not disturb dut_in; the new stimulus takes effect only on the next load_emu.

Optional Feature:
- Macro: EMU_CYCLE_CNT_EN.
- Defined:
  - 32-bit counter cyc increments on every dut_ce pulse; wraps at 2^32-1 → 0; reset to 0.
  - Readable at addresses NO..NO+3, LSB first.
  - The 4-byte value is snapshotted when Addr_emu==NO is read, so multi-byte reads are coherent.
  - A load_emu with Addr_emu == 2^ADDR_W-1 also clears cyc.
- Undefined: no counter logic; those addresses read 0x00; load_emu ignores Addr_emu.

Test Plan:
- Reset, then read all addresses → Dout_emu=0x00, busy_emu=0, dut_ce=0; assert rst_emu_n low mid-RUN → dut_ce and busy_emu drop without waiting for a clock.
- IN_WIDTH=OUT_WIDTH=24: write 0x11,0x22,0x33 to addr 0..2, load_emu → dut_in=0x332211; loopback dut_out=dut_in, get_emu → reads of addr 0..2 return 0x11,0x22,0x33 one cycle after Addr_emu.
- run_emu with Din_emu=5 on a counter DUT → exactly 5 contiguous dut_ce pulses, busy_emu high 6 cycles, readback = start+5.
- run_emu with Din_emu=0 → no dut_ce, busy_emu stays 0; load_emu+get_emu+wr_emu asserted together → only the load executes, stimulus bank unchanged.
- IN_WIDTH=12: write 0xFF to addr 1 → dut_in[11:8]=0xF after load; write to addr 5 → ignored; read addr 7 → 0x00.
- EMU_CYCLE_CNT_EN: runs of 200, then 100 → addr NO..NO+3 read 0x2C,0x01,0x00,0x00; load_emu at top address → reads 0.
